// File: rtl/demux4_tdm.sv
// demux4_tdm: 1-to-4 time-division demultiplexer with frame-sync lock.
// Rebuilds four lanes from a serial stream and emits whole frames.
module demux4_tdm #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               din_sync,
    output logic [4*WIDTH-1:0] dout,
    output logic               dout_valid,
    output logic               sync_err,
    output logic [1:0]         chan,
    output logic               locked
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;
    logic [WIDTH-1:0] lane2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            chan       <= 2'd0;
            lane0      <= '0;
            lane1      <= '0;
            lane2      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                unique case (state)
                    HUNT: begin
                        if (din_sync) begin
                            lane0  <= din;
                            chan   <= 2'd1;
                            state  <= RUN;
                            locked <= 1'b1;
                        end
                    end
                    RUN: begin
                        // sync wins over frame completion, even at chan 3
                        if (din_sync) begin
                            sync_err <= (chan != 2'd0);
                            lane0    <= din;
                            chan     <= 2'd1;
                        end else begin
                            unique case (chan)
                                2'd0: lane0 <= din;
                                2'd1: lane1 <= din;
                                2'd2: lane2 <= din;
                                2'd3: begin
                                    dout       <= {din, lane2, lane1, lane0};
                                    dout_valid <= 1'b1;
                                end
                            endcase
                            chan <= chan + 2'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
